// File: rtl/lclk_hs_word_tx_if.sv
// Word-transfer handshake bundle shared by local source, transmitter and remote receiver.
//   in_data/in_valid/in_ready : local valid/ready word input
//   tx_req/tx_data            : level request and held word towards the remote domain
//   tx_ack                    : remote acknowledge (asynchronous to the local clock)
// master: the transmitter view; slave: the environment view (source + remote receiver).
interface lclk_hs_word_tx_if #(
  parameter int unsigned DATA_W = 12
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;

  modport master (
    input  in_data,
    input  in_valid,
    input  tx_ack,
    output in_ready,
    output tx_req,
    output tx_data
  );

  modport slave (
    output in_data,
    output in_valid,
    output tx_ack,
    input  in_ready,
    input  tx_req,
    input  tx_data
  );
endinterface

// File: rtl/lclk_hs_word_tx.sv
// Transmit end of a 4-phase req/ack word transfer, clocked entirely by lclk.
// Accepts words on a valid/ready input, holds them on tx_data behind a level tx_req, and waits
// for the remote tx_ack to rise and fall. One-entry holding buffer lets a second word queue up
// during a transfer; the next transfer launches straight out of REQ_LO without an idle cycle.
// Ports:
//   lclk, rst_n    : clock, asynchronous active-low reset
//   bus (master)   : in_data/in_valid/in_ready, tx_req/tx_data, tx_ack
//   done           : one-cycle pulse per completed transfer
//   busy           : transfer in progress or buffer occupied
//   xfer_cnt       : completed transfer count, wraps
//   timeout_err    : sticky flag, a handshake phase lasted TIMEOUT cycles
//   err_clr        : clears timeout_err (a coincident new timeout wins)
// SYNC_STAGES legal range is 2..4; TIMEOUT = 0 disables the timeout flag.
module lclk_hs_word_tx #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic                lclk,
  input  logic                rst_n,
  lclk_hs_word_tx_if.master   bus,
  output logic                done,
  output logic                busy,
  output logic [15:0]         xfer_cnt,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int unsigned     WaitW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_q, done_d;
  logic [15:0]            xfer_cnt_q, xfer_cnt_d;
  logic                   err_q, err_d;
  logic [WaitW-1:0]       wait_q, wait_d;

  logic ack_s;
  logic accept;
  logic word_avail;
  logic launch;
  logic complete;
  logic timeout_set;

  assign ack_s      = sync_q[SYNC_STAGES-1];
  assign accept     = bus.in_valid & ~buf_full_q;
  // Buffered word has priority; otherwise the word accepted this cycle can launch.
  assign word_avail = buf_full_q | bus.in_valid;

  // tx_ack synchronizer
  always_ff @(posedge lclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tx_ack};
    end
  end

  // State register
  always_ff @(posedge lclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A stale high ack (e.g. after reset) holds off launching.
        if (!ack_s && word_avail) launch = 1'b1;
      end
      StReqHi: begin
        if (ack_s) state_d = StReqLo;
      end
      StReqLo: begin
        if (!ack_s) begin
          complete = 1'b1;
          if (word_avail) launch = 1'b1;
          else            state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (launch) state_d = StReqHi;
  end

  // Output / datapath next-state logic
  always_comb begin
    req_d       = req_q;
    data_d      = data_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    done_d      = complete;
    xfer_cnt_d  = complete ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    wait_d      = wait_q;
    timeout_set = 1'b0;

    if (launch) begin
      req_d  = 1'b1;
      data_d = buf_full_q ? buf_q : bus.in_data;
      if (buf_full_q) buf_full_d = 1'b0;
    end else if (state_q == StReqHi && ack_s) begin
      req_d = 1'b0;
    end

    // accept and a buffer drain are mutually exclusive since in_ready is low while full
    if (accept && !launch) begin
      buf_d      = bus.in_data;
      buf_full_d = 1'b1;
    end

    if (state_q == StIdle || state_d != state_q) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + WaitW'(1);
    end

    // Flag only the cycle the counter reaches its limit, so err_clr works while still stuck.
    if (TIMEOUT != 0 && wait_q != WaitMax && wait_d == WaitMax) timeout_set = 1'b1;
    err_d = timeout_set | (err_q & ~err_clr);
  end

  always_ff @(posedge lclk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      data_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      done_q     <= 1'b0;
      xfer_cnt_q <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      req_q      <= req_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      done_q     <= done_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign bus.in_ready = ~buf_full_q;
  assign bus.tx_req   = req_q;
  assign bus.tx_data  = data_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle) | buf_full_q;
  assign xfer_cnt     = xfer_cnt_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_lclk_hs_word_tx.sv
// Directed bench for lclk_hs_word_tx. dut_a: SYNC_STAGES=2, TIMEOUT=8 (most scenarios);
// dut_b: SYNC_STAGES=3, TIMEOUT=0 (synchronizer latency, timeout disabled).
module tb_lclk_hs_word_tx;

  localparam int unsigned DW = 12;

  logic lclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 lclk = ~lclk;

  lclk_hs_word_tx_if #(.DATA_W(DW)) bus_a ();
  lclk_hs_word_tx_if #(.DATA_W(DW)) bus_b ();

  logic        done_a, busy_a, err_a, err_clr_a;
  logic [15:0] cnt_a;
  logic        done_b, busy_b, err_b, err_clr_b;
  logic [15:0] cnt_b;

  lclk_hs_word_tx #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(8)) dut_a (
    .lclk        (lclk),
    .rst_n       (rst_n),
    .bus         (bus_a),
    .done        (done_a),
    .busy        (busy_a),
    .xfer_cnt    (cnt_a),
    .timeout_err (err_a),
    .err_clr     (err_clr_a)
  );

  lclk_hs_word_tx #(.DATA_W(DW), .SYNC_STAGES(3), .TIMEOUT(0)) dut_b (
    .lclk        (lclk),
    .rst_n       (rst_n),
    .bus         (bus_b),
    .done        (done_b),
    .busy        (busy_b),
    .xfer_cnt    (cnt_b),
    .timeout_err (err_b),
    .err_clr     (err_clr_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] seen [3];
  logic          rad  [3];
  logic [DW-1:0] s1;
  logic          r1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  // Offer one word on dut_a and hold it until accepted.
  task automatic send_a(input logic [DW-1:0] w);
    int k;
    bus_a.in_data  = w;
    bus_a.in_valid = 1'b1;
    k = 0;
    while (bus_a.in_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check_eq("send_ready_wait", 32'(bus_a.in_ready), 32'd1);
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  // Remote receiver for dut_a: ack hi_dly cycles after req, drop ack lo_dly cycles after req
  // falls, then wait for the done pulse and report tx_req at that moment.
  task automatic remote_xfer_a(input int hi_dly, input int lo_dly,
                               output logic [DW-1:0] got, output logic req_at_done);
    int k;
    k = 0;
    while (bus_a.tx_req !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check_eq("rem_req_rise_wait", 32'(bus_a.tx_req), 32'd1);
    repeat (hi_dly) tick();
    got          = bus_a.tx_data;
    bus_a.tx_ack = 1'b1;
    k = 0;
    while (bus_a.tx_req !== 1'b0 && k < 50) begin
      tick();
      k++;
    end
    check_eq("rem_req_fall_wait", 32'(bus_a.tx_req), 32'd0);
    check_eq("rem_data_hold", 32'(bus_a.tx_data), 32'(got));
    repeat (lo_dly) tick();
    bus_a.tx_ack = 1'b0;
    k = 0;
    while (done_a !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check_eq("rem_done_wait", 32'(done_a), 32'd1);
    req_at_done = bus_a.tx_req;
  endtask

  task automatic feed_b2b();
    logic [DW-1:0] words [3];
    int k;
    words[0] = 12'h001;
    words[1] = 12'h002;
    words[2] = 12'h003;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_data  = words[i];
      bus_a.in_valid = 1'b1;
      if (i == 2) check_eq("b2b_third_stalls", 32'(bus_a.in_ready), 32'd0);
      k = 0;
      while (bus_a.in_ready !== 1'b1 && k < 100) begin
        tick();
        k++;
      end
      check_eq("b2b_ready_wait", 32'(bus_a.in_ready), 32'd1);
      tick();
    end
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.in_data  = '0;
    bus_a.in_valid = 1'b0;
    bus_a.tx_ack   = 1'b0;
    bus_b.in_data  = '0;
    bus_b.in_valid = 1'b0;
    bus_b.tx_ack   = 1'b0;
    err_clr_a      = 1'b0;
    err_clr_b      = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_tx_req", 32'(bus_a.tx_req), 32'd0);
    check_eq("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
    check_eq("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_cnt", 32'(cnt_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);

    // Single word, cycle-exact
    bus_a.in_data  = 12'h5A3;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check_eq("sw_req_rise", 32'(bus_a.tx_req), 32'd1);
    check_eq("sw_data", 32'(bus_a.tx_data), 32'h5A3);
    repeat (3) tick();
    bus_a.tx_ack = 1'b1;
    repeat (2) tick();
    check_eq("sw_req_still_hi", 32'(bus_a.tx_req), 32'd1);
    tick();
    check_eq("sw_req_fall", 32'(bus_a.tx_req), 32'd0);
    check_eq("sw_data_hold", 32'(bus_a.tx_data), 32'h5A3);
    repeat (3) tick();
    bus_a.tx_ack = 1'b0;
    repeat (2) tick();
    check_eq("sw_no_early_done", 32'(done_a), 32'd0);
    tick();
    check_eq("sw_done", 32'(done_a), 32'd1);
    check_eq("sw_cnt", 32'(cnt_a), 32'd1);
    tick();
    check_eq("sw_done_one_cycle", 32'(done_a), 32'd0);
    check_eq("sw_idle_busy", 32'(busy_a), 32'd0);

    // Back-to-back through the holding buffer
    fork
      feed_b2b();
      begin
        for (int i = 0; i < 3; i++) remote_xfer_a(2, 2, seen[i], rad[i]);
      end
    join
    check_eq("b2b_word0", 32'(seen[0]), 32'h001);
    check_eq("b2b_word1", 32'(seen[1]), 32'h002);
    check_eq("b2b_word2", 32'(seen[2]), 32'h003);
    check_eq("b2b_relaunch0", 32'(rad[0]), 32'd1);
    check_eq("b2b_relaunch1", 32'(rad[1]), 32'd1);
    check_eq("b2b_last_idle", 32'(rad[2]), 32'd0);
    check_eq("b2b_cnt", 32'(cnt_a), 32'd4);
    tick();
    check_eq("b2b_not_busy", 32'(busy_a), 32'd0);

    // Timeout with ack held low
    bus_a.in_data  = 12'h7E1;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check_eq("to_launch", 32'(bus_a.tx_req), 32'd1);
    repeat (7) tick();
    check_eq("to_not_yet", 32'(err_a), 32'd0);
    tick();
    check_eq("to_set", 32'(err_a), 32'd1);
    check_eq("to_req_held", 32'(bus_a.tx_req), 32'd1);
    repeat (5) tick();
    check_eq("to_sticky", 32'(err_a), 32'd1);
    remote_xfer_a(1, 2, s1, r1);
    check_eq("to_late_data", 32'(s1), 32'h7E1);
    check_eq("to_late_cnt", 32'(cnt_a), 32'd5);
    check_eq("to_err_after", 32'(err_a), 32'd1);
    tick();
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check_eq("to_clr", 32'(err_a), 32'd0);

    // err_clr coincident with a fresh timeout
    bus_a.in_data  = 12'h0C3;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (7) tick();
    check_eq("co_pre", 32'(err_a), 32'd0);
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check_eq("co_set_wins", 32'(err_a), 32'd1);
    remote_xfer_a(1, 2, s1, r1);
    check_eq("co_cnt", 32'(cnt_a), 32'd6);
    tick();
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;

    // Reset mid-transfer with ack high
    bus_a.in_data  = 12'h111;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check_eq("rm_launch", 32'(bus_a.tx_req), 32'd1);
    tick();
    bus_a.tx_ack = 1'b1;
    rst_n        = 1'b0;
    #1;
    check_eq("rm_req_drop", 32'(bus_a.tx_req), 32'd0);
    check_eq("rm_cnt", 32'(cnt_a), 32'd0);
    check_eq("rm_data", 32'(bus_a.tx_data), 32'd0);
    check_eq("rm_busy", 32'(busy_a), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    bus_a.in_data  = 12'h222;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check_eq("rm_held", 32'(bus_a.tx_req), 32'd0);
    check_eq("rm_buffered", 32'(bus_a.in_ready), 32'd0);
    check_eq("rm_busy_buf", 32'(busy_a), 32'd1);
    repeat (4) tick();
    check_eq("rm_still_held", 32'(bus_a.tx_req), 32'd0);
    bus_a.tx_ack = 1'b0;
    repeat (2) tick();
    check_eq("rm_pre_launch", 32'(bus_a.tx_req), 32'd0);
    tick();
    check_eq("rm_launch2", 32'(bus_a.tx_req), 32'd1);
    check_eq("rm_data2", 32'(bus_a.tx_data), 32'h222);
    check_eq("rm_drained", 32'(bus_a.in_ready), 32'd1);
    remote_xfer_a(2, 2, s1, r1);
    check_eq("rm_cnt_after", 32'(cnt_a), 32'd1);
    tick();

    // Counter wrap, preloaded
    force dut_a.xfer_cnt_q = 16'hFFFE;
    tick();
    release dut_a.xfer_cnt_q;
    check_eq("wr_preload", 32'(cnt_a), 32'hFFFE);
    send_a(12'hABC);
    remote_xfer_a(1, 1, s1, r1);
    check_eq("wr_ffff", 32'(cnt_a), 32'hFFFF);
    tick();
    send_a(12'hDEF);
    remote_xfer_a(1, 1, s1, r1);
    check_eq("wr_wrap_cnt", 32'(cnt_a), 32'h0000);
    check_eq("wr_wrap_done", 32'(done_a), 32'd1);
    check_eq("wr_wrap_data", 32'(s1), 32'hDEF);
    tick();

    // Synchronizer latency on the 3-stage instance, timeout disabled
    check_eq("sy_rst_cnt", 32'(cnt_b), 32'd0);
    bus_b.in_data  = 12'h3C5;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    check_eq("sy_launch", 32'(bus_b.tx_req), 32'd1);
    check_eq("sy_data", 32'(bus_b.tx_data), 32'h3C5);
    repeat (20) tick();
    bus_b.tx_ack = 1'b1;
    repeat (3) tick();
    check_eq("sy_req_before", 32'(bus_b.tx_req), 32'd1);
    check_eq("sy_no_timeout", 32'(err_b), 32'd0);
    tick();
    check_eq("sy_req_fall", 32'(bus_b.tx_req), 32'd0);
    repeat (2) tick();
    bus_b.tx_ack = 1'b0;
    repeat (3) tick();
    check_eq("sy_done_before", 32'(done_b), 32'd0);
    tick();
    check_eq("sy_done", 32'(done_b), 32'd1);
    check_eq("sy_cnt", 32'(cnt_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
